serial_tx_arbiter: RTL and testbench

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_pkg.sv | 16 +
 rtl/serial_tx_arbiter_rr_arbiter.sv | 26 ++
 rtl/serial_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit arbiter: frame FSM states and line levels.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first active request after the pointer, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] sel_o,
    output logic            valid_o
);

    logic [PW-1:0] idx_s;

    // Scan NREQ slots starting just after the pointer; the first hit wins
    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s        = PW'((int'(ptr_i) + k) % NREQ);
            sel_o[idx_s] = sel_o[idx_s] | (req_i[idx_s] & ~valid_o);
            valid_o      = valid_o | req_i[idx_s];
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto one serial line (start, data LSB first, stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [NREQ-1:0]    iREQ,
    input  logic [NREQ*DW-1:0] iDATA,
    output logic [NREQ-1:0]    oGNT,
    output logic               oSD,
    output logic               oBUSY
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            sd_q, sd_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] sel_s;
    logic            valid_s;
    logic [PW-1:0]   sel_idx_s;
`ifdef SERIAL_TX_PARITY_EN
    logic            par_q, par_d;

    function automatic logic even_parity(input logic [DW-1:0] d);
        return ^d;
    endfunction
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i   (iREQ),
        .ptr_i   (ptr_q),
        .sel_o   (sel_s),
        .valid_o (valid_s)
    );

    // Binary index of the one-hot selection, used for the data mux and pointer update
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_idx_s = sel_idx_s | (sel_s[i] ? PW'(i) : PW'(0));
        end
    end

    // Frame sequencing; every output is the registered value of what goes on the line next
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ptr_d   = ptr_q;
        sd_d    = sd_q;
        busy_d  = busy_q;
        gnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                if (valid_s) begin
                    state_d = START;
                    sd_d    = START_BIT;
                    busy_d  = 1'b1;
                    gnt_d   = sel_s;
                    ptr_d   = sel_idx_s;
                    shreg_d = iDATA[sel_idx_s*DW +: DW];
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = even_parity(iDATA[sel_idx_s*DW +: DW]);
`endif
                end else begin
                    state_d = IDLE;
                    sd_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                sd_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CW'(DW - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PARITY;
                    sd_d    = par_q;
`else
                    state_d = STOP;
                    sd_d    = STOP_BIT;
`endif
                end else begin
                    sd_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
                state_d = STOP;
                sd_d    = STOP_BIT;
`else
                state_d = IDLE;
                sd_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                sd_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and gives requester 0 first turn
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ptr_q   <= PW'(NREQ - 1);
            sd_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ptr_q   <= ptr_d;
            sd_q    <= sd_d;
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign oSD   = sd_q;
    assign oBUSY = busy_q;
    assign oGNT  = gnt_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter (NREQ=4, DW=8); follows SERIAL_TX_PARITY_EN if defined.
module tb_serial_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_LEN = DW + 3;
`else
    localparam int FRAME_LEN = DW + 2;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = 4'b0000;
    logic [31:0] data  = 32'h0;
    logic [3:0]  gnt;
    logic        sd;
    logic        busy;

    typedef struct {
        int         idx;
        logic [7:0] byte_v;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [7:0] data;
        int         idx;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   tests  = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iREQ   (req),
        .iDATA  (data),
        .oGNT   (gnt),
        .oSD    (sd),
        .oBUSY  (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winning lane gets d exactly; the other lanes get distinct different bytes
    task automatic set_lanes(input logic [7:0] d, input int idx);
        for (int i = 0; i < NREQ; i++) begin
            data[i*8 +: 8] = d ^ (8'h11 * 8'(i ^ idx));
        end
    endtask

    task automatic wait_grant(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (gnt != 4'b0000) ok = 1'b1;
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called at the START negedge; returns busy cycles of this frame
    task automatic count_frame(output int n);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    // Frame monitor: pops the scoreboard on each grant and checks the serial bits
    always begin : monitor
        @(negedge clk);
        if (mon_en && rst_n && gnt != 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_grant", {28'b0, gnt}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("grant_onehot", {28'b0, gnt}, {28'b0, 4'b0001 << mon_e.idx});
                chk("start_bit", {31'b0, sd}, 32'd0);
                chk("start_busy", {31'b0, busy}, 32'd1);
                for (int b = 0; b < DW; b++) begin
                    @(negedge clk);
                    chk("data_bit", {31'b0, sd}, {31'b0, mon_e.byte_v[b]});
                    chk("gnt_pulse", {28'b0, gnt}, 32'd0);
                end
`ifdef SERIAL_TX_PARITY_EN
                @(negedge clk);
                chk("parity_bit", {31'b0, sd}, {31'b0, ^mon_e.byte_v});
`endif
                @(negedge clk);
                chk("stop_bit", {31'b0, sd}, 32'd1);
                chk("stop_busy", {31'b0, busy}, 32'd1);
            end
        end
    end

    initial begin : main
        int n;
        int lows;
        bit ok;
        bit g3;

        vecs[0] = '{4'b0010, 8'hA5, 1};
        vecs[1] = '{4'b0011, 8'h3C, 0};
        vecs[2] = '{4'b1001, 8'h07, 3};
        vecs[3] = '{4'b1001, 8'hFF, 0};
        vecs[4] = '{4'b0110, 8'h00, 1};
        vecs[5] = '{4'b1100, 8'h81, 2};
        vecs[6] = '{4'b1000, 8'hC3, 3};

        // Reset held four cycles
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_sd", {31'b0, sd}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_gnt", {28'b0, gnt}, 32'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single frames from the vector table
        for (int v = 0; v < 7; v++) begin
            req = vecs[v].req;
            set_lanes(vecs[v].data, vecs[v].idx);
            sb_q.push_back('{vecs[v].idx, vecs[v].data});
            wait_grant("tbl_grant", ok);
            req = 4'b0000;
            if (ok) begin
                count_frame(n);
                chk("tbl_frame_len", n, FRAME_LEN);
            end
            @(negedge clk);
        end

        // Fairness: all requesting, pointer now at 3 so order is 0,1,2,3,0
        data = 32'h379E62C1;
        sb_q.push_back('{0, 8'hC1});
        sb_q.push_back('{1, 8'h62});
        sb_q.push_back('{2, 8'h9E});
        sb_q.push_back('{3, 8'h37});
        sb_q.push_back('{0, 8'hC1});
        req = 4'b1111;
        wait_grant("fair_grant", ok);
        lows = 0;
        for (int k = 1; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!busy) lows++;
            end while (gnt == 4'b0000 && n < 30);
            chk("fair_spacing", n, FRAME_LEN);
        end
        req = 4'b0000;
        count_frame(n);
        chk("fair_last_len", n, FRAME_LEN);
        chk("fair_busy_low", lows, 0);
        @(negedge clk);

        // Request 3 pulsed mid-frame and withdrawn before the stop bit
        set_lanes(8'h3C, 1);
        req = 4'b0010;
        sb_q.push_back('{1, 8'h3C});
        wait_grant("wd_grant", ok);
        req = 4'b0000;
        g3  = 1'b0;
        repeat (2) @(negedge clk);
        req = 4'b1000;
        repeat (2) begin
            @(negedge clk);
            g3 |= gnt[3];
        end
        req = 4'b0000;
        repeat (FRAME_LEN + 3) begin
            @(negedge clk);
            g3 |= gnt[3];
        end
        chk("wd_gnt3", {31'b0, g3}, 32'd0);
        chk("wd_busy", {31'b0, busy}, 32'd0);
        chk("wd_sd_idle", {31'b0, sd}, 32'd1);

        // Reset during data bit 3
        mon_en = 1'b0;
        set_lanes(8'hE7, 2);
        req = 4'b0100;
        wait_grant("mid_grant", ok);
        chk("mid_grant_vec", {28'b0, gnt}, 32'h4);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        chk("mid_bit3", {31'b0, sd}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_sd", {31'b0, sd}, 32'd1);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_gnt", {28'b0, gnt}, 32'd0);
        req = 4'b0101;
        set_lanes(8'h5A, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_sd", {31'b0, sd}, 32'd1);
        sb_q.push_back('{0, 8'h5A});
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_grant("post_rst_grant", ok);
        req = 4'b0000;
        if (ok) begin
            count_frame(n);
            chk("post_rst_len", n, FRAME_LEN);
        end
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
